// File: rtl/mem_stage_if.sv
// Pipeline-side and data-memory-side signals of the memory-access stage.
// The stage itself connects through the master modport; the environment uses slave.
interface mem_stage_if;
   logic [31:0] alu;
   logic        aluToReg;
   logic [1:0]  memSize;
   logic [1:0]  memOp;
   logic [4:0]  rd;
   logic [31:0] rs2Val;
   logic        stallOut;
   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic [3:0]  dmemBe;
   logic        dmemAck;
   logic [31:0] dmemRdata;
   logic [31:0] wbData;
   logic [4:0]  wbRd;
   logic        wbWe;
   logic        fault;
   logic [1:0]  faultCause;
   logic [31:0] faultAddr;

   modport master (
      input  alu, aluToReg, memSize, memOp, rd, rs2Val, dmemAck, dmemRdata,
      output stallOut, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
      output wbData, wbRd, wbWe, fault, faultCause, faultAddr
   );

   modport slave (
      output alu, aluToReg, memSize, memOp, rd, rs2Val, dmemAck, dmemRdata,
      input  stallOut, dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
      input  wbData, wbRd, wbWe, fault, faultCause, faultAddr
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues load/store on a req/ack bus, stalls upstream while
// busy, and produces registered writeback results and fault reports.
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input logic         clk,
   input logic         reset,
   mem_stage_if.master bus
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CntLast =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire_q, retire_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic             wb_we_q, wb_we_d;
   logic             fault_q, fault_d;
   logic [1:0]       cause_q, cause_d;
   logic [31:0]      faddr_q, faddr_d;
   logic             stall_c;

   logic        is_mem, is_bad, misaligned, timeout;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, shifted, load_c;

   assign is_mem     = (bus.memOp != 2'b00);
   assign is_bad     = (bus.memSize == 2'b11);
   assign misaligned = ((bus.memSize == 2'b01) && bus.alu[0]) ||
                       ((bus.memSize == 2'b10) && (bus.alu[1:0] != 2'b00));
   assign timeout    = TimeoutEn && !bus.dmemAck && (cnt_q == CntLast);
   assign shifted    = bus.dmemRdata >> {bus.alu[1:0], 3'b000};

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = bus.rs2Val;
      load_c  = shifted;
      unique case (bus.memSize)
         2'b00: begin
            be_c    = 4'b0001 << bus.alu[1:0];
            wdata_c = {4{bus.rs2Val[7:0]}};
            load_c  = (bus.memOp == 2'b01) ? {{24{shifted[7]}}, shifted[7:0]}
                                           : {24'h0, shifted[7:0]};
         end
         2'b01: begin
            be_c    = bus.alu[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{bus.rs2Val[15:0]}};
            load_c  = (bus.memOp == 2'b01) ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'h0, shifted[15:0]};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         retire_q  <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
         wb_we_q   <= 1'b0;
         fault_q   <= 1'b0;
         cause_q   <= '0;
         faddr_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retire_q  <= retire_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         wb_data_q <= wb_data_d;
         wb_rd_q   <= wb_rd_d;
         wb_we_q   <= wb_we_d;
         fault_q   <= fault_d;
         cause_q   <= cause_d;
         faddr_q   <= faddr_d;
      end
   end

   // After a timeout the stalled instruction is still on the inputs; retire_q lets it
   // leave for one cycle without being reissued.
   always_comb begin
      state_d  = state_q;
      retire_d = 1'b0;
      unique case (state_q)
         StIdle: if (!retire_q && is_mem && !is_bad && !misaligned) state_d = StBusy;
         StBusy: begin
            if (bus.dmemAck || timeout) state_d = StIdle;
            retire_d = !bus.dmemAck && timeout;
         end
      endcase
   end

   always_comb begin
      stall_c   = 1'b0;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      wb_data_d = wb_data_q;
      wb_rd_d   = wb_rd_q;
      wb_we_d   = 1'b0;
      fault_d   = 1'b0;
      cause_d   = cause_q;
      faddr_d   = faddr_q;
      unique case (state_q)
         StIdle: begin
            if (retire_q) begin
               stall_c = 1'b0;
            end else if (!is_mem) begin
               wb_data_d = bus.alu;
               wb_rd_d   = bus.rd;
               wb_we_d   = bus.aluToReg && (bus.rd != 5'd0);
            end else if (is_bad || misaligned) begin
               fault_d = 1'b1;
               cause_d = is_bad ? 2'b11 : 2'b01;
               faddr_d = bus.alu;
            end else begin
               stall_c = 1'b1;
               req_d   = 1'b1;
               we_d    = (bus.memOp == 2'b10);
               addr_d  = {bus.alu[31:2], 2'b00};
               be_d    = be_c;
               wdata_d = wdata_c;
               cnt_d   = '0;
            end
         end
         StBusy: begin
            stall_c = !bus.dmemAck;
            if (bus.dmemAck) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               be_d  = 4'b0000;
               if (!we_q) begin
                  wb_data_d = load_c;
                  wb_rd_d   = bus.rd;
                  wb_we_d   = (bus.rd != 5'd0);
               end
            end else if (timeout) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = 4'b0000;
               fault_d = 1'b1;
               cause_d = 2'b10;
               faddr_d = bus.alu;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   assign bus.stallOut   = stall_c & reset;
   assign bus.dmemReq    = req_q;
   assign bus.dmemWe     = we_q;
   assign bus.dmemAddr   = addr_q;
   assign bus.dmemWdata  = wdata_q;
   assign bus.dmemBe     = be_q;
   assign bus.wbData     = wb_data_q;
   assign bus.wbRd       = wb_rd_q;
   assign bus.wbWe       = wb_we_q;
   assign bus.fault      = fault_q;
   assign bus.faultCause = cause_q;
   assign bus.faultAddr  = faddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized sequence checked against a
// transaction-level model of the stage.
module tb_mem_stage;
   localparam int TO = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      int          stall;
      int          req;
      int          faults;
      int          wbwes;
      bit          hung;
      bit          unstable;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] wb_data;
      logic [4:0]  wb_rd;
      logic [1:0]  cause;
      logic [31:0] faddr;
   } obs_t;

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_be(logic [31:0] a, logic [1:0] sz);
      int w   = 1 << sz;
      int off = int'(a[1:0]);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + w);
      return r;
   endfunction

   function automatic logic [31:0] m_wdata(logic [31:0] d, logic [1:0] sz);
      int w = 1 << sz;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % w) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] rdata, logic [31:0] a, logic [1:0] sz,
                                          logic [1:0] op);
      int w   = 1 << sz;
      int off = int'(a[1:0]);
      logic [31:0] r = 32'h0;
      for (int i = 0; i < w; i++) r[8*i +: 8] = rdata[8*(off+i) +: 8];
      if (op == 2'b01 && w < 4 && r[8*w-1])
         for (int i = w; i < 4; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic bit m_illegal(logic [31:0] a, logic [1:0] sz);
      if (sz == 2'b11) return 1'b1;
      return (int'(a[1:0]) % (1 << sz)) != 0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic set_idle();
      bus.alu = 32'h0; bus.aluToReg = 1'b0; bus.memSize = 2'b00; bus.memOp = 2'b00;
      bus.rd = 5'd0; bus.rs2Val = 32'h0; bus.dmemAck = 1'b0; bus.dmemRdata = 32'h0;
   endtask

   // Presents one instruction until the stage lets it go; ack_at is the BUSY cycle index
   // (0-based) on which ack is returned, -1 for never. Called at posedge+1.
   task automatic run_op(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                         input logic [4:0] r, input logic atr, input logic [31:0] d,
                         input int ack_at, input logic [31:0] rdata, output obs_t o);
      bit done = 1'b0;
      o.stall = 0; o.req = 0; o.faults = 0; o.wbwes = 0; o.hung = 1'b0; o.unstable = 1'b0;
      o.we = 1'b0; o.addr = '0; o.wdata = '0; o.be = '0; o.wb_data = '0; o.wb_rd = '0;
      o.cause = '0; o.faddr = '0;
      bus.alu = a; bus.memSize = sz; bus.memOp = op; bus.rd = r; bus.aluToReg = atr;
      bus.rs2Val = d;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         bus.dmemAck   = bus.dmemReq && (o.req == ack_at);
         bus.dmemRdata = bus.dmemAck ? rdata : 32'hA5A5_5A5A;
         #1;
         if (bus.fault) begin o.faults++; o.cause = bus.faultCause; o.faddr = bus.faultAddr; end
         if (bus.wbWe) o.wbwes++;
         if (bus.dmemReq) begin
            if (o.req == 0) begin
               o.we = bus.dmemWe; o.addr = bus.dmemAddr; o.wdata = bus.dmemWdata; o.be = bus.dmemBe;
            end else if (o.we !== bus.dmemWe || o.addr !== bus.dmemAddr ||
                         o.wdata !== bus.dmemWdata || o.be !== bus.dmemBe) begin
               o.unstable = 1'b1;
            end
            o.req++;
         end
         if (bus.stallOut) o.stall++;
         else done = 1'b1;
         @(posedge clk); #1;
      end
      o.hung = !done;
      bus.dmemAck = 1'b0;
      if (bus.fault) begin o.faults++; o.cause = bus.faultCause; o.faddr = bus.faultAddr; end
      if (bus.wbWe) o.wbwes++;
      o.wb_data = bus.wbData;
      o.wb_rd   = bus.wbRd;
      set_idle();
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      set_idle();
      bus.alu = 32'h100; bus.memSize = 2'b10; bus.memOp = 2'b01; bus.rd = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.stallOut !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", bus.stallOut); end
      n_checks++; if (bus.dmemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", bus.dmemReq); end
      n_checks++;
      if ({bus.wbData, bus.wbRd, bus.wbWe, bus.fault, bus.faultCause, bus.faultAddr,
           bus.dmemAddr, bus.dmemBe, bus.dmemWe, bus.dmemWdata} !== '0) begin
         n_fail++; $display("FAIL rst_regs: registered outputs not all zero, wbData=%h faultAddr=%h", bus.wbData, bus.faultAddr);
      end
      set_idle();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_passthrough();
      bus.alu = 32'h1234_5678; bus.rd = 5'd5; bus.aluToReg = 1'b1; bus.memOp = 2'b00;
      #1;
      n_checks++; if (bus.stallOut !== 1'b0) begin n_fail++; $display("FAIL pt_stall: got %0b want 0", bus.stallOut); end
      @(posedge clk); #1;
      n_checks++; if (bus.wbData !== 32'h1234_5678) begin n_fail++; $display("FAIL pt_data: got %h want 12345678", bus.wbData); end
      n_checks++; if (bus.wbRd !== 5'd5) begin n_fail++; $display("FAIL pt_rd: got %0d want 5", bus.wbRd); end
      n_checks++; if (bus.wbWe !== 1'b1) begin n_fail++; $display("FAIL pt_we: got %0b want 1", bus.wbWe); end
      bus.rd = 5'd0;
      @(posedge clk); #1;
      n_checks++; if (bus.wbWe !== 1'b0) begin n_fail++; $display("FAIL pt_rd0_we: got %0b want 0", bus.wbWe); end
      set_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_load_byte();
      obs_t o;
      run_op(32'h103, 2'b00, 2'b01, 5'd9, 1'b0, 32'h0, 3, 32'h80FF_1122, o);
      n_checks++; if (o.addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr: got %h want 00000100", o.addr); end
      n_checks++; if (o.be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", o.be); end
      n_checks++; if (o.stall !== 4) begin n_fail++; $display("FAIL lb_stall: got %0d cycles want 4", o.stall); end
      n_checks++; if (o.wb_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", o.wb_data); end
      n_checks++; if (o.wbwes !== 1 || o.wb_rd !== 5'd9) begin n_fail++; $display("FAIL lb_we: got we=%0d rd=%0d want 1/9", o.wbwes, o.wb_rd); end
      run_op(32'h103, 2'b00, 2'b11, 5'd9, 1'b0, 32'h0, 3, 32'h80FF_1122, o);
      n_checks++; if (o.wb_data !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", o.wb_data); end
   endtask

   task automatic test_store_half();
      obs_t o;
      run_op(32'h202, 2'b01, 2'b10, 5'd4, 1'b0, 32'hDEAD_BEEF, 1, 32'h0, o);
      n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %0b want 1", o.we); end
      n_checks++; if (o.be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", o.be); end
      n_checks++; if (o.wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", o.wdata); end
      n_checks++; if (o.addr !== 32'h200) begin n_fail++; $display("FAIL sh_addr: got %h want 00000200", o.addr); end
      n_checks++; if (o.wbwes !== 0) begin n_fail++; $display("FAIL sh_wbwe: got %0d want 0", o.wbwes); end
   endtask

   task automatic test_fault();
      obs_t o;
      run_op(32'h301, 2'b10, 2'b01, 5'd6, 1'b0, 32'h0, 0, 32'h0, o);
      n_checks++; if (o.req !== 0) begin n_fail++; $display("FAIL mis_req: got %0d req cycles want 0", o.req); end
      n_checks++; if (o.faults !== 1) begin n_fail++; $display("FAIL mis_fault: got %0d pulses want 1", o.faults); end
      n_checks++; if (o.cause !== 2'b01 || o.faddr !== 32'h301) begin n_fail++; $display("FAIL mis_cause: got %b/%h want 01/00000301", o.cause, o.faddr); end
      n_checks++; if (o.stall !== 0 || o.wbwes !== 0) begin n_fail++; $display("FAIL mis_stall: got stall=%0d we=%0d want 0/0", o.stall, o.wbwes); end
      run_op(32'h300, 2'b11, 2'b01, 5'd6, 1'b0, 32'h0, 0, 32'h0, o);
      n_checks++; if (o.cause !== 2'b11 || o.faults !== 1) begin n_fail++; $display("FAIL bad_cause: got %b n=%0d want 11 n=1", o.cause, o.faults); end
      n_checks++; if (bus.faultCause !== 2'b11) begin n_fail++; $display("FAIL cause_held: got %b want 11", bus.faultCause); end
   endtask

   task automatic test_timeout();
      obs_t o;
      run_op(32'h440, 2'b10, 2'b01, 5'd7, 1'b0, 32'h0, -1, 32'h0, o);
      n_checks++; if (o.req !== TO) begin n_fail++; $display("FAIL to_req: got %0d cycles want %0d", o.req, TO); end
      n_checks++; if (o.faults !== 1 || o.cause !== 2'b10 || o.faddr !== 32'h440) begin
         n_fail++; $display("FAIL to_fault: got n=%0d cause=%b addr=%h want 1/10/00000440", o.faults, o.cause, o.faddr);
      end
      n_checks++; if (o.stall !== TO + 1) begin n_fail++; $display("FAIL to_stall: got %0d want %0d", o.stall, TO + 1); end
      n_checks++; if (o.wbwes !== 0) begin n_fail++; $display("FAIL to_wbwe: got %0d want 0", o.wbwes); end
      run_op(32'h440, 2'b10, 2'b01, 5'd7, 1'b0, 32'h0, TO - 1, 32'hCAFE_F00D, o);
      n_checks++; if (o.faults !== 0 || o.wbwes !== 1) begin n_fail++; $display("FAIL to_late_ack: got faults=%0d we=%0d want 0/1", o.faults, o.wbwes); end
      n_checks++; if (o.wb_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL to_late_data: got %h want cafef00d", o.wb_data); end
   endtask

   task automatic test_reset_mid_busy();
      bus.alu = 32'h500; bus.memSize = 2'b10; bus.memOp = 2'b01; bus.rd = 5'd3;
      @(posedge clk); #1;
      n_checks++; if (bus.dmemReq !== 1'b1) begin n_fail++; $display("FAIL rmb_pre_req: got %0b want 1", bus.dmemReq); end
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      n_checks++; if (bus.dmemReq !== 1'b0 || bus.stallOut !== 1'b0) begin
         n_fail++; $display("FAIL rmb_drop: got req=%0b stall=%0b want 0/0", bus.dmemReq, bus.stallOut);
      end
      set_idle();
      bus.alu = 32'h77; bus.rd = 5'd3;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      bus.dmemAck = 1'b1; bus.dmemRdata = 32'h1111_2222;
      @(posedge clk); #1;
      bus.dmemAck = 1'b0;
      n_checks++; if (bus.wbWe !== 1'b0 || bus.wbData !== 32'h77) begin
         n_fail++; $display("FAIL rmb_stray_ack: got we=%0b data=%h want 0/00000077", bus.wbWe, bus.wbData);
      end
      set_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      obs_t o;
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a     = $urandom;
         logic [1:0]  sz    = 2'($urandom_range(0, 3));
         logic [1:0]  op    = 2'($urandom_range(0, 3));
         logic [4:0]  r     = 5'($urandom_range(0, 31));
         logic        atr   = 1'($urandom_range(0, 1));
         logic [31:0] d     = $urandom;
         logic [31:0] rdata = $urandom;
         int          ack   = $urandom_range(0, 5);
         bit          tmo;
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a[1:0] = 2'b00;
         if (ack == 5) ack = -1;
         tmo = (ack < 0) || (ack >= TO);
         run_op(a, sz, op, r, atr, d, ack, rdata, o);
         n_checks++; if (o.hung) begin n_fail++; $display("FAIL rnd_hung: op %0d never released", n); end
         if (op == 2'b00) begin
            n_checks++;
            if (o.stall !== 0 || o.wbwes !== int'(atr && r != 0) || o.wb_data !== a || o.wb_rd !== r) begin
               n_fail++; $display("FAIL rnd_alu[%0d]: got stall=%0d we=%0d data=%h rd=%0d want 0/%0d/%h/%0d", n, o.stall, o.wbwes, o.wb_data, o.wb_rd, atr && r != 0, a, r);
            end
         end else if (m_illegal(a, sz)) begin
            n_checks++;
            if (o.req !== 0 || o.faults !== 1 || o.cause !== (sz == 2'b11 ? 2'b11 : 2'b01) || o.faddr !== a || o.wbwes !== 0) begin
               n_fail++; $display("FAIL rnd_fault[%0d]: got req=%0d n=%0d cause=%b addr=%h we=%0d", n, o.req, o.faults, o.cause, o.faddr, o.wbwes);
            end
         end else begin
            n_checks++;
            if (o.addr !== {a[31:2], 2'b00} || o.be !== m_be(a, sz) || o.we !== (op == 2'b10) ||
                (op == 2'b10 && o.wdata !== m_wdata(d, sz)) || o.unstable) begin
               n_fail++; $display("FAIL rnd_bus[%0d]: got addr=%h be=%b we=%0b wdata=%h unstable=%0b want be=%b wdata=%h", n, o.addr, o.be, o.we, o.wdata, o.unstable, m_be(a, sz), m_wdata(d, sz));
            end
            n_checks++;
            if (o.req !== (tmo ? TO : ack + 1) || o.stall !== (tmo ? TO + 1 : ack + 1) || o.faults !== int'(tmo)) begin
               n_fail++; $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d faults=%0d ack_at=%0d", n, o.req, o.stall, o.faults, ack);
            end
            n_checks++;
            if (o.wbwes !== int'(!tmo && op != 2'b10 && r != 0) ||
                (!tmo && op != 2'b10 && r != 0 && (o.wb_data !== m_load(rdata, a, sz, op) || o.wb_rd !== r))) begin
               n_fail++; $display("FAIL rnd_wb[%0d]: got we=%0d data=%h want data=%h", n, o.wbwes, o.wb_data, m_load(rdata, a, sz, op));
            end
         end
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_passthrough();
      test_load_byte();
      test_store_half();
      test_fault();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
